// File: rtl/multi_edge_pulse.sv
// Per-channel edge-to-pulse converter: synchroniser, TRIGGER-qualified edge detect, IDLE/ACTIVE/HOLD FSM.
// Optional sticky pending flags are built only when MULTI_EDGE_PULSE_PENDING_EN is defined.
module multi_edge_pulse #(
  parameter int                    CHANNELS    = 4,
  parameter logic [1:0]            TRIGGER     = 2'b11,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    PULSE_WIDTH = 1,
  parameter int                    HOLDOFF     = 0,
  parameter int                    RETRIGGER   = 0,
  parameter logic [CHANNELS-1:0]   IDLE_LEVEL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ctrl,
  input  logic [CHANNELS-1:0] mask,
`ifdef MULTI_EDGE_PULSE_PENDING_EN
  input  logic [CHANNELS-1:0] pending_clr,
  output logic [CHANNELS-1:0] pending,
`endif
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // 8 bits cover PULSE_WIDTH-1 (max 255) and HOLDOFF-1 (max 254).
  localparam logic [7:0] PW_LOAD = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] HO_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;
  localparam bit         HAS_HO  = (HOLDOFF > 0);
  localparam bit         RETRIG  = (RETRIGGER != 0);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] cur_s;
  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] fall_s;
  logic [CHANNELS-1:0] valid_s;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [7:0]          cnt_q   [CHANNELS];
  logic [7:0]          cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] pulse_d;
  logic [CHANNELS-1:0] busy_q;
  logic [CHANNELS-1:0] busy_d;

  // Synchroniser chain followed by the previous-sample flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= IDLE_LEVEL;
      end
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q[0] <= ctrl;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur_s   = sync_q[SYNC_STAGES-1];
  assign rise_s  = cur_s & ~prev_q;
  assign fall_s  = ~cur_s & prev_q;
  assign valid_s = ((rise_s & {CHANNELS{TRIGGER[0]}}) |
                    (fall_s & {CHANNELS{TRIGGER[1]}})) & ~mask;

  // Per-channel next-state, counter and output decode.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        ST_IDLE: begin
          if (valid_s[c]) begin
            state_d[c] = ST_ACTIVE;
            cnt_d[c]   = PW_LOAD;
          end else begin
            state_d[c] = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (RETRIG && valid_s[c]) begin
            cnt_d[c] = PW_LOAD;
          end else if (cnt_q[c] == 8'd0) begin
            if (HAS_HO) begin
              state_d[c] = ST_HOLD;
              cnt_d[c]   = HO_LOAD;
            end else begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = 8'd0;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - 8'd1;
          end
        end
        ST_HOLD: begin
          // Edges are ignored here; one landing on the exit cycle is dropped.
          if (cnt_q[c] == 8'd0) begin
            state_d[c] = ST_IDLE;
          end else begin
            cnt_d[c] = cnt_q[c] - 8'd1;
          end
        end
        default: begin
          state_d[c] = ST_IDLE;
          cnt_d[c]   = 8'd0;
        end
      endcase
      pulse_d[c] = (state_d[c] == ST_ACTIVE);
      busy_d[c]  = (state_d[c] != ST_IDLE);
    end
  end

  // State, counter and registered outputs; reset drops pulse immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= 8'd0;
      end
      pulse_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

`ifdef MULTI_EDGE_PULSE_PENDING_EN
  logic [CHANNELS-1:0] pending_q;
  logic [CHANNELS-1:0] pending_d;

  // Sticky flag: a new valid edge beats a simultaneous clear.
  assign pending_d = (pending_q & ~pending_clr) | valid_s;

  // Pending flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`endif

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Self-checking bench: five configurations of multi_edge_pulse share stimulus and are
// compared each cycle against a timeline model (accepted edge -> pulse/busy end times).
module tb_multi_edge_pulse;

  localparam int NI = 5;
  localparam int CH = 4;
  localparam int         SY [NI] = '{2, 2, 3, 2, 1};
  localparam int         PW [NI] = '{1, 4, 4, 2, 3};
  localparam int         HO [NI] = '{0, 0, 0, 3, 0};
  localparam int         RT [NI] = '{0, 0, 1, 0, 1};
  localparam logic [1:0] TR [NI] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
  localparam logic [3:0] IL [NI] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ctrl;
  logic [3:0] mask;
  logic [3:0] pulse_w [NI];
  logic [3:0] busy_w  [NI];
`ifdef MULTI_EDGE_PULSE_PENDING_EN
  logic [3:0] pclr;
  logic [3:0] pend_w   [NI];
  logic [3:0] exp_pend [NI];
`endif

  logic [3:0] hist [NI][8];
  int         act_until  [NI][CH];
  int         busy_until [NI][CH];
  logic [3:0] exp_pulse [NI];
  logic [3:0] exp_busy  [NI];
  int         cyc;
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  multi_edge_pulse #(.CHANNELS(CH), .TRIGGER(TR[0]), .SYNC_STAGES(SY[0]), .PULSE_WIDTH(PW[0]),
                     .HOLDOFF(HO[0]), .RETRIGGER(RT[0]), .IDLE_LEVEL(IL[0])) u_d0 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .mask(mask),
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    .pending_clr(pclr), .pending(pend_w[0]),
`endif
    .pulse(pulse_w[0]), .busy(busy_w[0]));

  multi_edge_pulse #(.CHANNELS(CH), .TRIGGER(TR[1]), .SYNC_STAGES(SY[1]), .PULSE_WIDTH(PW[1]),
                     .HOLDOFF(HO[1]), .RETRIGGER(RT[1]), .IDLE_LEVEL(IL[1])) u_d1 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .mask(mask),
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    .pending_clr(pclr), .pending(pend_w[1]),
`endif
    .pulse(pulse_w[1]), .busy(busy_w[1]));

  multi_edge_pulse #(.CHANNELS(CH), .TRIGGER(TR[2]), .SYNC_STAGES(SY[2]), .PULSE_WIDTH(PW[2]),
                     .HOLDOFF(HO[2]), .RETRIGGER(RT[2]), .IDLE_LEVEL(IL[2])) u_d2 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .mask(mask),
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    .pending_clr(pclr), .pending(pend_w[2]),
`endif
    .pulse(pulse_w[2]), .busy(busy_w[2]));

  multi_edge_pulse #(.CHANNELS(CH), .TRIGGER(TR[3]), .SYNC_STAGES(SY[3]), .PULSE_WIDTH(PW[3]),
                     .HOLDOFF(HO[3]), .RETRIGGER(RT[3]), .IDLE_LEVEL(IL[3])) u_d3 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .mask(mask),
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    .pending_clr(pclr), .pending(pend_w[3]),
`endif
    .pulse(pulse_w[3]), .busy(busy_w[3]));

  multi_edge_pulse #(.CHANNELS(CH), .TRIGGER(TR[4]), .SYNC_STAGES(SY[4]), .PULSE_WIDTH(PW[4]),
                     .HOLDOFF(HO[4]), .RETRIGGER(RT[4]), .IDLE_LEVEL(IL[4])) u_d4 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .mask(mask),
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    .pending_clr(pclr), .pending(pend_w[4]),
`endif
    .pulse(pulse_w[4]), .busy(busy_w[4]));

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) hist[i][k] = IL[i];
      for (int c = 0; c < CH; c++) begin
        act_until[i][c]  = -1;
        busy_until[i][c] = -1;
      end
      exp_pulse[i] = 4'h0;
      exp_busy[i]  = 4'h0;
`ifdef MULTI_EDGE_PULSE_PENDING_EN
      exp_pend[i]  = 4'h0;
`endif
    end
  endtask

  // Edge seen at clock u compares ctrl sampled SYNC and SYNC+1 clocks earlier.
  // Accepted edge at u: pulse during [u, u+PW), busy during [u, u+PW+HOLDOFF).
  task automatic model_step();
    logic [3:0] cur;
    logic [3:0] prv;
    logic [1:0] tr;
    logic       vld;
    for (int i = 0; i < NI; i++) begin
      for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = ctrl;
      cur = hist[i][SY[i]];
      prv = hist[i][SY[i]+1];
      tr  = TR[i];
      for (int c = 0; c < CH; c++) begin
        vld = ((cur[c] & ~prv[c] & tr[0]) | (~cur[c] & prv[c] & tr[1])) & ~mask[c];
        if (vld) begin
          if (cyc > busy_until[i][c]) begin
            act_until[i][c]  = cyc + PW[i];
            busy_until[i][c] = cyc + PW[i] + HO[i];
          end else if (RT[i] != 0 && cyc <= act_until[i][c]) begin
            act_until[i][c]  = cyc + PW[i];
            busy_until[i][c] = cyc + PW[i] + HO[i];
          end
        end
        exp_pulse[i][c] = (cyc < act_until[i][c]);
        exp_busy[i][c]  = (cyc < busy_until[i][c]);
`ifdef MULTI_EDGE_PULSE_PENDING_EN
        exp_pend[i][c]  = (exp_pend[i][c] & ~pclr[c]) | vld;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ctrl = 4'h0;
    mask = 4'h0;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (pulse_w[i] !== 4'h0 || busy_w[i] !== 4'h0) begin
        errors++;
        $display("FAIL reset inst%0d: pulse=%b busy=%b, expected 0000/0000", i, pulse_w[i], busy_w[i]);
      end
    end
  endtask

  task automatic test_default_edge();
    int hi_cnt;
    int first_hi;
    rst = 1'b0;
    repeat (10) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL idle inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
        end
      end
    end
    for (int phase = 0; phase < 2; phase++) begin
      ctrl[0]  = (phase == 0);
      hi_cnt   = 0;
      first_hi = -1;
      for (int t = 0; t < 8; t++) begin
        tick();
        if (pulse_w[0][0] === 1'b1) begin
          hi_cnt++;
          if (first_hi < 0) first_hi = t;
        end
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
            errors++;
            $display("FAIL default_edge inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
          end
        end
      end
      checks++;
      if (hi_cnt !== 1 || first_hi !== SY[0]) begin
        errors++;
        $display("FAIL default_latency phase%0d: high_cycles=%0d first=%0d, expected 1 at %0d", phase, hi_cnt, first_hi, SY[0]);
      end
    end
  endtask

  task automatic test_retrigger();
    int n1;
    int n2;
    n1 = 0;
    n2 = 0;
    for (int t = 0; t < 16; t++) begin
      ctrl[0] = (t != 1);
      tick();
      if (pulse_w[1][0] === 1'b1) n1++;
      if (pulse_w[2][0] === 1'b1) n2++;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL retrigger inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
        end
      end
    end
    checks++;
    if (n1 !== 4 || n2 !== 6) begin
      errors++;
      $display("FAIL retrigger_width: no_retrig=%0d retrig=%0d cycles, expected 4 and 6", n1, n2);
    end
  endtask

  task automatic test_holdoff();
    int p1;
    int b1;
    int p2;
    p1 = 0;
    b1 = 0;
    p2 = 0;
    for (int t = 0; t < 20; t++) begin
      ctrl[1] = (t < 3) || (t >= 12);
      tick();
      if (t < 12) begin
        if (pulse_w[3][1] === 1'b1) p1++;
        if (busy_w[3][1]  === 1'b1) b1++;
      end else begin
        if (pulse_w[3][1] === 1'b1) p2++;
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL holdoff inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
        end
      end
    end
    checks++;
    if (p1 !== 2 || b1 !== 5 || p2 !== 2) begin
      errors++;
      $display("FAIL holdoff_counts: pulse1=%0d busy1=%0d pulse2=%0d, expected 2 5 2", p1, b1, p2);
    end
  endtask

  task automatic test_mask();
    int masked_hi;
    int together;
    masked_hi = 0;
    together  = 0;
    mask = 4'b0010;
    for (int t = 0; t < 24; t++) begin
      if (t % 4 == 0) ctrl = ~ctrl;
      tick();
      if (pulse_w[0][1] === 1'b1) masked_hi++;
      if (pulse_w[0] === 4'b1101) together++;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL mask inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
        end
      end
    end
    mask = 4'h0;
    checks++;
    if (masked_hi !== 0 || together !== 6) begin
      errors++;
      $display("FAIL mask_counts: masked_high=%0d simultaneous=%0d, expected 0 and 6", masked_hi, together);
    end
  endtask

  task automatic test_idle_level();
    int hi4;
    hi4  = 0;
    ctrl = 4'hF;
    rst  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (pulse_w[4] !== 4'h0) hi4++;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL idle_level inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
        end
      end
    end
    checks++;
    if (hi4 !== 0) begin
      errors++;
      $display("FAIL idle_level_release: pulse cycles=%0d, expected 0", hi4);
    end
    ctrl[0] = 1'b0;
    repeat (3) tick();
    checks++;
    if (pulse_w[1][0] !== 1'b1 || exp_pulse[1][0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: pulse=%b model=%b, expected 1", pulse_w[1][0], exp_pulse[1][0]);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (pulse_w[i] !== 4'h0 || busy_w[i] !== 4'h0) begin
        errors++;
        $display("FAIL async_reset inst%0d: pulse=%b busy=%b, expected 0000/0000", i, pulse_w[i], busy_w[i]);
      end
    end
    repeat (2) tick();
    ctrl = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

`ifdef MULTI_EDGE_PULSE_PENDING_EN
  task automatic test_pending();
    pclr = 4'hF;
    tick();
    pclr = 4'h0;
    repeat (10) tick();
    ctrl[2] = ~ctrl[2];
    repeat (SY[0]) tick();
    pclr[2] = 1'b1;
    tick();
    pclr = 4'h0;
    checks++;
    if (pend_w[0][2] !== 1'b1 || pend_w[0] !== exp_pend[0]) begin
      errors++;
      $display("FAIL pending_set_wins: pending=%b, expected bit2=1 model=%b", pend_w[0], exp_pend[0]);
    end
    pclr[2] = 1'b1;
    tick();
    pclr = 4'h0;
    checks++;
    if (pend_w[0][2] !== 1'b0 || pend_w[0] !== exp_pend[0]) begin
      errors++;
      $display("FAIL pending_clear: pending=%b, expected bit2=0 model=%b", pend_w[0], exp_pend[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5, 0) == 0) ctrl[c] = ~ctrl[c];
      end
      mask = ($urandom_range(7, 0) == 0) ? 4'($urandom()) : 4'h0;
`ifdef MULTI_EDGE_PULSE_PENDING_EN
      pclr = 4'($urandom());
`endif
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (pulse_w[i] !== exp_pulse[i] || busy_w[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: pulse=%b busy=%b, expected %b/%b", i, cyc, pulse_w[i], busy_w[i], exp_pulse[i], exp_busy[i]);
        end
`ifdef MULTI_EDGE_PULSE_PENDING_EN
        checks++;
        if (pend_w[i] !== exp_pend[i]) begin
          errors++;
          $display("FAIL random_pending inst%0d cyc%0d: pending=%b, expected %b", i, cyc, pend_w[i], exp_pend[i]);
        end
`endif
      end
    end
    mask = 4'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    ctrl   = 4'h0;
    mask   = 4'h0;
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    pclr   = 4'h0;
`endif
    model_reset();
    @(negedge clk);
    test_reset();
    test_default_edge();
    test_retrigger();
    test_holdoff();
    test_mask();
    test_idle_level();
`ifdef MULTI_EDGE_PULSE_PENDING_EN
    test_pending();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_edge_pulse.md
MULTI_EDGE_PULSE -- requirements
Module: multi_edge_pulse

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent channels, range 1..32.
REQ-002 SHALL have parameter TRIGGER, default 2'b11: 2'b11 both edges, 2'b01 rising, 2'b10 falling, 2'b00 never triggers.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, range 1..4.
REQ-004 SHALL have parameter PULSE_WIDTH, default 1: pulse length in clk cycles, range 1..256.
REQ-005 SHALL have parameter HOLDOFF, default 0: dead cycles after each pulse, range 0..255.
REQ-006 SHALL have parameter RETRIGGER, default 0: 1 = an edge during a pulse restarts the width count.
REQ-007 SHALL have parameter IDLE_LEVEL, default all zeros, width CHANNELS: per-channel ctrl level assumed at reset.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL have port ctrl  input  CHANNELS  control levels, asynchronous to clk permitted.
REQ-011 SHALL have port mask  input  CHANNELS  1 = ignore edges on that channel.
REQ-012 SHALL have port pulse  output  CHANNELS  registered per-channel pulse.
REQ-013 SHALL have port busy  output  CHANNELS  1 while channel is not IDLE.

Function
REQ-014 Each channel SHALL pass ctrl through SYNC_STAGES flops, then one previous-sample flop; an edge is the last sync stage differing from the previous sample, qualified by TRIGGER.
REQ-015 Only an unmasked, TRIGGER-qualified edge SHALL count as a valid edge; masking SHALL NOT cut short a pulse already in progress.
REQ-016 Latency: pulse SHALL rise on the (SYNC_STAGES+1)th rising clk edge after the first edge that samples the new ctrl level.
REQ-017 Per-channel FSM states SHALL be IDLE, ACTIVE, HOLD.
REQ-018 IDLE + valid edge -> ACTIVE, counter loaded with PULSE_WIDTH-1, pulse=1.
REQ-019 ACTIVE: counter decrements each cycle; at 0 -> HOLD (counter loaded with HOLDOFF-1) if HOLDOFF>0, else IDLE; pulse=0 on exit.
REQ-020 ACTIVE + valid edge: RETRIGGER=1 SHALL reload PULSE_WIDTH-1 and stay ACTIVE; RETRIGGER=0 SHALL ignore the edge.
REQ-021 HOLD SHALL ignore all edges, decrement each cycle, and go to IDLE at 0.
REQ-022 A valid edge in the cycle an exit to IDLE occurs SHALL be dropped; a pulse is produced only by edges seen in IDLE.
REQ-023 pulse SHALL be high for exactly PULSE_WIDTH cycles per accepted edge when not retriggered.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be handled in the same cycle.
REQ-025 Counters SHALL be sized to the parameter range and SHALL never wrap.

Reset
REQ-026 While rst=1, sync and previous-sample flops SHALL equal IDLE_LEVEL, all FSMs IDLE, counters 0, pulse=0, busy=0.
REQ-027 Assertion of rst mid-pulse SHALL drop pulse asynchronously; deassertion SHALL NOT generate a pulse while ctrl equals IDLE_LEVEL.

Configuration
REQ-028 With macro MULTI_EDGE_PULSE_PENDING_EN defined, ports pending (output, CHANNELS) and pending_clr (input, CHANNELS) SHALL exist; pending bit sets on every valid edge in any state, clears on pending_clr, and set SHALL win over clear in the same cycle; reset value 0.
REQ-029 Without MULTI_EDGE_PULSE_PENDING_EN, those ports and registers SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Defaults: ctrl[0] 0->1 at cycle 10, held -> pulse[0] high at cycle 13 only; ctrl[0] 1->0 -> one further 1-cycle pulse.
REQ-031 PULSE_WIDTH=4, RETRIGGER=0: rising edges two cycles apart -> single 4-cycle pulse; RETRIGGER=1 -> 6-cycle pulse.
REQ-032 PULSE_WIDTH=2, HOLDOFF=3: edge during HOLD -> no pulse, busy high 5 cycles total; edge after HOLD -> new pulse.
REQ-033 mask[1]=1 with toggling ctrl[1] -> pulse[1] stays 0; channels 0,2,3 pulse simultaneously on simultaneous edges.
REQ-034 IDLE_LEVEL=4'b1111, TRIGGER=2'b01, ctrl=4'hF through reset release -> no pulse; rst during ACTIVE -> pulse=0 immediately.
REQ-035 With MULTI_EDGE_PULSE_PENDING_EN defined: edge and pending_clr in same cycle -> pending=1; pending_clr alone next cycle -> pending=0.
